iob_ibex_mem_arb: RTL

Two-port arbiter merging Ibex instruction-fetch and LSU data requests onto the single Ibex-protocol request port of the Ibex-to-AXI bridge. It grants one requester per cycle, holds a stalled selection stable until the bridge grants it, and records the source of each granted request in an in-order tag FIFO. Responses (`rvalid`/`rdata`/`err`) are routed back to the correct port. It sits between the Ibex core and the bridge inside the CPU wrapper.

---
 rtl/iob_ibex_mem_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/iob_ibex_mem_arb.sv
// Merges Ibex instruction-fetch and LSU requests onto one Ibex-protocol port and routes responses back by tag.
// Define IOB_IBEX_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over instr.
module iob_ibex_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic              data_err_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic              mem_err_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              spurious_o
);

  // Handshake: a request transfers in the cycle mem_req_o and mem_gnt_i are both high;
  // responses come back in grant order, one per mem_rvalid_i, with no back-pressure.

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  logic               lock_q;
  logic               lock_src_q;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [MAX_OUT-1:0] tag_q;
  logic               spurious_q;

  logic pick_data;
  logic sel_data;
  logic sel_req;
  logic full;
  logic has_tag;
  logic fwd_req;
  logic grant;
  logic pop;
  logic head_data;

`ifdef IOB_IBEX_ARB_RR_EN
  logic rr_data_q;

  always_comb begin
    pick_data = data_req_i;
    if (instr_req_i && data_req_i) pick_data = rr_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_data_q <= 1'b1;
    end else if (grant) begin
      rr_data_q <= ~sel_data;
    end
  end
`else
  always_comb begin
    pick_data = data_req_i;
  end
`endif

  always_comb begin
    sel_data  = lock_q ? lock_src_q : pick_data;
    sel_req   = sel_data ? data_req_i : instr_req_i;
    full      = (count_q == FULL_CNT);
    has_tag   = (count_q != '0);
    // A full FIFO blocks forwarding even when a pop lands in the same cycle.
    fwd_req   = !rst_i && sel_req && !full;
    grant     = fwd_req && mem_gnt_i;
    pop       = !rst_i && mem_rvalid_i && has_tag;
    head_data = tag_q[rd_ptr_q];
  end

  always_comb begin
    mem_req_o      = fwd_req;
    mem_we_o       = !rst_i && sel_data && data_we_i;
    mem_be_o       = rst_i ? 4'h0 : (sel_data ? data_be_i : 4'hF);
    mem_addr_o     = rst_i ? '0 : (sel_data ? data_addr_i : instr_addr_i);
    mem_wdata_o    = (rst_i || !sel_data) ? '0 : data_wdata_i;
    instr_gnt_o    = grant && (sel_data == SRC_INSTR);
    data_gnt_o     = grant && (sel_data == SRC_DATA);
    instr_rvalid_o = pop && (head_data == SRC_INSTR);
    data_rvalid_o  = pop && (head_data == SRC_DATA);
    instr_err_o    = instr_rvalid_o && mem_err_i;
    data_err_o     = data_rvalid_o && mem_err_i;
    instr_rdata_o  = rst_i ? '0 : mem_rdata_i;
    data_rdata_o   = rst_i ? '0 : mem_rdata_i;
    spurious_o     = spurious_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      // Hold the stalled selection so address, data and source stay stable.
      if (fwd_req && !mem_gnt_i) begin
        lock_q     <= 1'b1;
        lock_src_q <= sel_data;
      end else if (grant) begin
        lock_q <= 1'b0;
      end
      if (grant) begin
        tag_q[wr_ptr_q] <= sel_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      spurious_q <= mem_rvalid_i && !has_tag;
    end
  end

endmodule
